uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter and counterpart of the receive path. It pulls bytes from a first-word-fall-through TX FIFO and serialises each one LSB-first onto o_tx. Each frame is start bit, DataLength data bits, an optional parity bit, then StopBits stop bits. Bit timing comes from the shared external prescaler: o_prescaler_en requests the prescaler, and i_strobe marks each bit boundary (one pulse every 16 i_clk at 16x oversampling).

Parameters:
- Parity, 1'b0: 1 appends a parity bit; 0 means no parity.
- ParityOdd, 1'b0: 1 selects odd parity, 0 selects even. Ignored when Parity=0.
- StopBits, 1: number of stop bits; legal values 1 or 2.
- DataLength, 8: data bits per frame; legal range 5..8.

Ports:
- i_clk  in  1  clock, baudrate*16. Reset is i_rst_n, synchronous, active-low; clock is i_clk.
- i_rst_n  in  1  synchronous active-low reset.
- i_fifo_data  in  8  FIFO head word, valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_read_en  out  1  one-cycle pop strobe.
- i_strobe  in  1  bit-period tick from the prescaler.
- o_prescaler_en  out  1  prescaler run enable.
- o_tx  out  1  serial line, registered.
- o_busy  out  1  high from leaving IDLE until the final stop bit ends.
- o_tx_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values:
  - state IDLE, o_tx=1, o_busy=0, o_tx_done=0.
  - o_fifo_read_en=0, o_prescaler_en=0.
  - Shift register cleared; bit counter = DataLength-1.
- States and transitions:
  - IDLE→START when i_fifo_empty=0.
  - START→DATA on i_strobe.
  - DATA→DATA on i_strobe while the bit counter is non-zero; the counter decrements.
  - DATA→PARITY, or →STOP when Parity=0, on i_strobe with the counter at 0.
  - PARITY→STOP on i_strobe.
  - STOP→IDLE on i_strobe once StopBits stop periods have elapsed. A stop-bit counter is required when StopBits=2.
- Load cycle (IDLE with i_fifo_empty=0), all in the same cycle:
  - o_fifo_read_en=1 combinationally.
  - i_fifo_data[DataLength-1:0] latched into the shift register.
  - Parity computed from the latched data: even = XOR of the bits; odd = inverted XOR.
- Line timing:
  - o_tx falls on the clock edge that ends the load cycle.
  - Each i_strobe in START/DATA/PARITY updates o_tx at that edge to the next frame bit.
  - Data bits are sent LSB first; the shift register shifts right.
  - o_tx=1 throughout STOP and IDLE.
- Prescaler handshake:
  - o_prescaler_en=1 in START, DATA, PARITY and STOP; 0 otherwise.
  - The prescaler restarts its count when en rises, so every bit lasts exactly 16 i_clk.
  - Frame length = (1+DataLength+Parity+StopBits)*16 clocks, measured from the o_tx falling edge.
- o_tx_done: asserted for one cycle in the cycle after the final STOP i_strobe, coinciding with the first IDLE cycle.
- Back-to-back frames: if the FIFO is non-empty in that IDLE cycle, the next byte loads immediately. The inter-frame gap is therefore the stop bits plus 1 clock.
- i_strobe asserted in IDLE is ignored.
- i_fifo_empty rising mid-frame has no effect on the current frame.
- i_fifo_data changing mid-frame has no effect; the byte was already latched.
- Reset mid-frame:
  - Next edge: o_tx=1, state IDLE, o_prescaler_en=0, o_busy=0.
  - The in-flight byte is lost; no extra FIFO pop and no o_tx_done.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- With the macro defined:
  - Extra port i_break (in, 1) is present, sampled only in IDLE, with priority over the FIFO.
  - When asserted, the block sends a break: o_tx=0 for (1+DataLength+Parity)*16 clocks, then a normal stop period.
  - No FIFO pop occurs; o_busy=1 for the duration; o_tx_done pulses at the end.
- Without the macro: the port and its logic are absent, and behaviour is unchanged.

Decomposition:
- Shared uart_pkg holds:
  - the TX state enum type: IDLE, START, DATA, PARITY, STOP, plus BREAK under the macro;
  - localparam OVERSAMPLE=16;
  - a parity function used by both TX and RX.
- Counter widths are derived with $clog2(DataLength).
- Single flat module; no sub-module is warranted because the prescaler is external and shared.

Test Plan:
- 8N1, FIFO holds 0x55:
  - one read_en pulse;
  - o_tx = 0,1,0,1,0,1,0,1,0 then stop 1, each bit 16 clocks;
  - o_tx_done at clock 160 after the start edge.
- Parity=1 even, byte 0x07 → parity bit 1. Same byte with ParityOdd=1 → parity bit 0. Frame is 176 clocks.
- FIFO holds 0xA5 then 0x3C:
  - two frames, second start edge exactly 1 clock after the first o_tx_done;
  - exactly two read_en pulses.
- FIFO empty for 1000 clocks: o_tx=1, o_busy=0, read_en=0, prescaler_en=0 throughout.
- Reset asserted during data bit 3 of 0xFF: o_tx=1 next edge, prescaler_en=0, no o_tx_done; a new byte afterwards transmits correctly.
- StopBits=2, byte 0x00: stop high for 32 clocks, frame 176 clocks. Under UART_TX_BREAK_EN, i_break in IDLE gives 144 low clocks, 16 high clocks, no FIFO pop.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, oversampling ratio and parity helper.
// BREAK exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } tx_state_e;

  // Even parity is the XOR of the first len bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [7:0] data, input int unsigned len,
                                       input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < len) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a FWFT FIFO and serialises them LSB first.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic Parity     = 1'b0,
  parameter logic ParityOdd  = 1'b0,
  parameter int   StopBits   = 1,
  parameter int   DataLength = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_fifo_data,
  input  logic       i_fifo_empty,
  output logic       o_fifo_read_en,
  input  logic       i_strobe,
`ifdef UART_TX_BREAK_EN
  input  logic       i_break,
`endif
  output logic       o_prescaler_en,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_tx_done
);

  // A break reuses the bit counter to time start, data and parity periods.
`ifdef UART_TX_BREAK_EN
  localparam int BitCntW = $clog2(DataLength + 2);
  localparam logic [BitCntW-1:0] BreakCntInit = BitCntW'(DataLength + int'(Parity));
`else
  localparam int BitCntW = $clog2(DataLength);
`endif
  localparam logic [BitCntW-1:0] DataCntInit = BitCntW'(DataLength - 1);

  tx_state_e              state, state_next;
  logic [DataLength-1:0]  shreg;
  logic [BitCntW-1:0]     bit_cnt;
  logic                   parity_bit;
  logic                   stop_cnt;
  logic                   tx_q, tx_next;
  logic                   done_q, done_next;
  logic                   load, shift, cnt_dec, stop_adv, read_en;
  logic                   last_stop;
`ifdef UART_TX_BREAK_EN
  logic                   brk_load;
`endif

  assign last_stop = (StopBits == 1) ? 1'b1 : stop_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_next    = tx_q;
    done_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    cnt_dec    = 1'b0;
    stop_adv   = 1'b0;
    read_en    = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_load   = 1'b0;
`endif
    case (state)
      IDLE: begin
        tx_next = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (i_break) begin
          state_next = BREAK;
          tx_next    = 1'b0;
          brk_load   = 1'b1;
        end else
`endif
        if (!i_fifo_empty) begin
          state_next = START;
          tx_next    = 1'b0;
          load       = 1'b1;
          read_en    = i_rst_n;
        end
      end
      START: if (i_strobe) begin
        state_next = DATA;
        tx_next    = shreg[0];
        shift      = 1'b1;
      end
      DATA: if (i_strobe) begin
        if (bit_cnt != '0) begin
          tx_next = shreg[0];
          shift   = 1'b1;
          cnt_dec = 1'b1;
        end else if (Parity) begin
          state_next = PARITY;
          tx_next    = parity_bit;
        end else begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      PARITY: if (i_strobe) begin
        state_next = STOP;
        tx_next    = 1'b1;
      end
      STOP: begin
        tx_next = 1'b1;
        if (i_strobe) begin
          if (last_stop) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        tx_next = 1'b0;
        if (i_strobe) begin
          if (bit_cnt == '0) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= DataCntInit;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      tx_q   <= tx_next;
      done_q <= done_next;
      if (load) begin
        shreg      <= i_fifo_data[DataLength-1:0];
        parity_bit <= calc_parity(i_fifo_data, DataLength, ParityOdd);
      end else if (shift) begin
        shreg <= shreg >> 1;
      end
      if (load)                bit_cnt <= DataCntInit;
`ifdef UART_TX_BREAK_EN
      else if (brk_load)       bit_cnt <= BreakCntInit;
`endif
      else if (cnt_dec)        bit_cnt <= bit_cnt - 1'b1;
      if (stop_adv)            stop_cnt <= 1'b1;
      else if (state != STOP)  stop_cnt <= 1'b0;
    end
  end

  assign o_tx           = tx_q;
  assign o_tx_done      = done_q;
  assign o_busy         = (state != IDLE);
  assign o_prescaler_en = (state != IDLE);
  assign o_fifo_read_en = read_en;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) with FIFO and prescaler models.
// Break coverage is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        force_strobe = 1'b0;
  logic [7:0]  fdata [4];
  logic [3:0]  fempty, rd_en, strobe, pen, tx, busy, done;
  logic [3:0]  pcnt [4];
  logic [7:0]  fmem [4][8];
  int          wptr [4];
  int          rptr [4];
  int          rd_pulses [4];
  int          done_cnt [4];
  int          cyc = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
`ifdef UART_TX_BREAK_EN
  logic [3:0]  brk = 4'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 4; k++) begin
      wptr[k] = 0;
      rptr[k] = 0;
      rd_pulses[k] = 0;
      done_cnt[k] = 0;
      pcnt[k] = '0;
    end
  end

  // Prescaler restarts whenever its enable is low, so each bit is OVERSAMPLE clocks.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (!pen[k]) pcnt[k] <= '0;
      else         pcnt[k] <= pcnt[k] + 4'd1;
      if (rd_en[k]) rd_pulses[k] <= rd_pulses[k] + 1;
      if (rd_en[k] && !fempty[k]) rptr[k] <= rptr[k] + 1;
      if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_env
    assign fempty[g] = (wptr[g] == rptr[g]);
    assign fdata[g]  = fmem[g][rptr[g] % 8];
    assign strobe[g] = (pen[g] && pcnt[g] == 4'(OVERSAMPLE - 1)) || force_strobe;
  end

  uart_tx #(.Parity(1'b0), .ParityOdd(1'b0), .StopBits(1), .DataLength(8)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_data(fdata[0]), .i_fifo_empty(fempty[0]),
    .o_fifo_read_en(rd_en[0]), .i_strobe(strobe[0]),
`ifdef UART_TX_BREAK_EN
    .i_break(brk[0]),
`endif
    .o_prescaler_en(pen[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_tx_done(done[0]));

  uart_tx #(.Parity(1'b1), .ParityOdd(1'b0), .StopBits(1), .DataLength(8)) u_8e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_data(fdata[1]), .i_fifo_empty(fempty[1]),
    .o_fifo_read_en(rd_en[1]), .i_strobe(strobe[1]),
`ifdef UART_TX_BREAK_EN
    .i_break(brk[1]),
`endif
    .o_prescaler_en(pen[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_tx_done(done[1]));

  uart_tx #(.Parity(1'b1), .ParityOdd(1'b1), .StopBits(1), .DataLength(8)) u_8o1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_data(fdata[2]), .i_fifo_empty(fempty[2]),
    .o_fifo_read_en(rd_en[2]), .i_strobe(strobe[2]),
`ifdef UART_TX_BREAK_EN
    .i_break(brk[2]),
`endif
    .o_prescaler_en(pen[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_tx_done(done[2]));

  uart_tx #(.Parity(1'b0), .ParityOdd(1'b0), .StopBits(2), .DataLength(8)) u_8n2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fifo_data(fdata[3]), .i_fifo_empty(fempty[3]),
    .o_fifo_read_en(rd_en[3]), .i_strobe(strobe[3]),
`ifdef UART_TX_BREAK_EN
    .i_break(brk[3]),
`endif
    .o_prescaler_en(pen[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_tx_done(done[3]));

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic [7:0] b);
    fmem[k][wptr[k] % 8] = b;
    wptr[k] = wptr[k] + 1;
  endtask

  task automatic wait_fall(input int k, input int limit, input string tag, output int t0);
    int found;
    found = 0;
    t0 = 0;
    for (int i = 0; i < limit && found == 0; i++) begin
      @(negedge clk);
      if (tx[k] === 1'b0) begin
        found = 1;
        t0 = cyc;
      end
    end
    check_output({tag, "_start_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_done(input int k, input int limit, input string tag, output int td);
    int found;
    found = 0;
    td = 0;
    for (int i = 0; i < limit && found == 0; i++) begin
      @(negedge clk);
      if (done[k] === 1'b1) begin
        found = 1;
        td = cyc;
      end
    end
    check_output({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  // Called on the negedge where the start bit was first seen; samples mid-bit.
  task automatic check_frames(input logic [3:0] mask, input int nbits,
                              input logic [3:0][15:0] exp, input string tag);
    repeat (OVERSAMPLE / 2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (OVERSAMPLE) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (mask[k])
          check_output($sformatf("%s_u%0d_bit%0d", tag, k, i), {31'b0, tx[k]}, {31'b0, exp[k][i]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0][15:0] exp;
    int t0, t1, td, td2, rp, dc, idle_bad;

    repeat (3) @(negedge clk);
    check_output("rst_tx", {31'b0, tx[0]}, 32'd1);
    check_output("rst_busy", {31'b0, busy[0]}, 32'd0);
    check_output("rst_done", {31'b0, done[0]}, 32'd0);
    check_output("rst_read_en", {31'b0, rd_en[0]}, 32'd0);
    check_output("rst_prescaler_en", {31'b0, pen[0]}, 32'd0);
    rst_n = 1'b1;

    // Empty FIFO for 1000 clocks, with spurious strobes that must be ignored.
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      force_strobe = (i >= 100 && i < 120);
      for (int k = 0; k < 4; k++)
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || rd_en[k] !== 1'b0 || pen[k] !== 1'b0)
          idle_bad++;
    end
    force_strobe = 1'b0;
    check_output("idle_violations", 32'(idle_bad), 32'd0);

    $display("[TB] 8N1 frame of 0x55");
    rp = rd_pulses[0];
    apply_stimulus(0, 8'h55);
    wait_fall(0, 20, "f55", t0);
    exp = '0;
    exp[0] = 16'b1_01010101_0;
    check_frames(4'b0001, 10, exp, "f55");
    wait_done(0, 100, "f55", td);
    check_output("f55_done_cycle", 32'(td - t0), 32'd160);
    check_output("f55_read_pulses", 32'(rd_pulses[0] - rp), 32'd1);

    $display("[TB] back-to-back 0xA5, 0x3C");
    rp = rd_pulses[0];
    apply_stimulus(0, 8'hA5);
    apply_stimulus(0, 8'h3C);
    wait_fall(0, 20, "fA5", t0);
    exp[0] = {6'b0, 1'b1, 8'hA5, 1'b0};
    check_frames(4'b0001, 10, exp, "fA5");
    wait_done(0, 100, "fA5", td);
    check_output("fA5_done_cycle", 32'(td - t0), 32'd160);
    wait_fall(0, 20, "f3C", t1);
    check_output("b2b_gap", 32'(t1 - td), 32'd1);
    exp[0] = {6'b0, 1'b1, 8'h3C, 1'b0};
    check_frames(4'b0001, 10, exp, "f3C");
    wait_done(0, 100, "f3C", td2);
    check_output("f3C_done_cycle", 32'(td2 - t1), 32'd160);
    check_output("b2b_read_pulses", 32'(rd_pulses[0] - rp), 32'd2);

    $display("[TB] parity even/odd on 0x07 and two stop bits on 0x00");
    apply_stimulus(1, 8'h07);
    apply_stimulus(2, 8'h07);
    apply_stimulus(3, 8'h00);
    wait_fall(1, 20, "fpar", t0);
    exp = '0;
    exp[1] = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0};
    exp[2] = {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
    exp[3] = {5'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    check_frames(4'b1110, 11, exp, "fpar");
    check_output("stop2_busy_in_2nd_stop", {31'b0, busy[3]}, 32'd1);
    wait_done(1, 100, "fpar", td);
    check_output("par_even_done_cycle", 32'(td - t0), 32'd176);
    check_output("par_odd_done", {31'b0, done[2]}, 32'd1);
    check_output("stop2_done", {31'b0, done[3]}, 32'd1);
    @(negedge clk);
    check_output("stop2_done_count", 32'(done_cnt[3]), 32'd1);

    $display("[TB] reset during data bit 3 of 0xFF");
    apply_stimulus(0, 8'hFF);
    wait_fall(0, 20, "fFF", t0);
    repeat (4 * OVERSAMPLE + OVERSAMPLE / 2) @(negedge clk);
    dc = done_cnt[0];
    rp = rd_pulses[0];
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrst_tx", {31'b0, tx[0]}, 32'd1);
    check_output("midrst_prescaler_en", {31'b0, pen[0]}, 32'd0);
    check_output("midrst_busy", {31'b0, busy[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_output("midrst_no_done", 32'(done_cnt[0] - dc), 32'd0);
    check_output("midrst_no_pop", 32'(rd_pulses[0] - rp), 32'd0);
    check_output("midrst_idle_tx", {31'b0, tx[0]}, 32'd1);
    apply_stimulus(0, 8'h96);
    wait_fall(0, 20, "f96", t0);
    exp = '0;
    exp[0] = {6'b0, 1'b1, 8'h96, 1'b0};
    check_frames(4'b0001, 10, exp, "f96");
    wait_done(0, 100, "f96", td);
    check_output("f96_done_cycle", 32'(td - t0), 32'd160);

`ifdef UART_TX_BREAK_EN
    $display("[TB] break on 8N1 instance");
    rp = rd_pulses[0];
    brk[0] = 1'b1;
    @(negedge clk);
    brk[0] = 1'b0;
    t0 = cyc;
    check_output("brk_first_low", {31'b0, tx[0]}, 32'd0);
    repeat (143) @(negedge clk);
    check_output("brk_last_low", {31'b0, tx[0]}, 32'd0);
    check_output("brk_busy", {31'b0, busy[0]}, 32'd1);
    @(negedge clk);
    check_output("brk_stop_high", {31'b0, tx[0]}, 32'd1);
    wait_done(0, 40, "brk", td);
    check_output("brk_done_cycle", 32'(td - t0), 32'd160);
    check_output("brk_no_pop", 32'(rd_pulses[0] - rp), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
